// File: rtl/lvds_sched_pkg.sv
// Shared types and constants for the LVDS UART frame scheduler.
// LVDS_SCHED_HDR_EN adds the HDR state that prefixes each frame with a sync byte.
`timescale 1ns/1ps
package lvds_sched_pkg;
  localparam int NUM_CH          = 4;
  localparam int CH_W            = 16;
  localparam int BYTES_PER_FRAME = 8;
  localparam int IDX_W           = 3;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
`ifdef LVDS_SCHED_HDR_EN
    HDR,
`endif
    LOAD,
    READY,
    START,
    WAIT
  } sched_state_e;

  // Byte i of the snapshot: ch0 low byte first, ch3 high byte last.
  function automatic logic [7:0] frame_byte(input logic [NUM_CH*CH_W-1:0] snap,
                                            input logic [IDX_W-1:0]       idx);
    return snap[{idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/sched_watchdog.sv
// Counts cycles spent waiting for txDone; expired fires on the TIMEOUT-th cycle.
`timescale 1ns/1ps
module sched_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk40M,
  input  logic nRst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)      cnt_d = '0;
    else if (count) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk40M or negedge nRst)
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign expired = count && (cnt_q == LAST);
endmodule

// File: rtl/lvds_uart_scheduler.sv
// Pops one word from each of four image FIFOs and streams the 8 bytes to a UART.
// Define LVDS_SCHED_HDR_EN to send HDR_BYTE ahead of every frame.
`timescale 1ns/1ps
module lvds_uart_scheduler
  import lvds_sched_pkg::*;
#(
  parameter int         TIMEOUT  = 65535,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                      clk40M,
  input  logic                      nRst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         empty,
  input  logic [NUM_CH*CH_W-1:0]    fifoOut,
  output logic [NUM_CH-1:0]         rd,
  output logic [7:0]                dataBus,
  output logic                      ldXmtDataReg,
  output logic                      byteReady,
  output logic                      tByte,
  input  logic                      txDone,
  output logic                      busy,
  output logic [15:0]               frameCnt,
  output logic                      txErr,
  input  logic                      errClr
);
  sched_state_e               state_q, state_d;
  logic [NUM_CH*CH_W-1:0]     snap_q, snap_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 data_q, data_d;
  logic [15:0]                frame_q, frame_d;
  logic                       err_q, err_d;
  logic                       hdr_q, hdr_d;
  logic                       wd_expired;
  logic                       timeout;
  logic                       start_ok;

  sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk40M  (clk40M),
    .nRst    (nRst),
    .clear   (state_q != WAIT),
    .count   (state_q == WAIT),
    .expired (wd_expired)
  );

  // Frames only start when every channel has a word, so channels stay aligned.
  assign start_ok = (state_q == IDLE) && en && (empty == '0);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    data_d  = data_q;
    frame_d = frame_q;
    hdr_d   = hdr_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_d = 8'h00;
        if (start_ok) state_d = POP;
      end
      POP: begin
        snap_d  = fifoOut;
        state_d = CAPT;
      end
      CAPT: begin
        idx_d   = '0;
`ifdef LVDS_SCHED_HDR_EN
        state_d = HDR;
`else
        data_d  = frame_byte(snap_q, '0);
        state_d = LOAD;
`endif
      end
`ifdef LVDS_SCHED_HDR_EN
      HDR: begin
        hdr_d   = 1'b1;
        data_d  = HDR_BYTE;
        state_d = LOAD;
      end
`endif
      LOAD:  state_d = READY;
      READY: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // txDone wins over a coincident timeout.
        if (txDone) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            data_d  = frame_byte(snap_q, idx_q);
            state_d = LOAD;
          end else if (idx_q == IDX_W'(BYTES_PER_FRAME - 1)) begin
            frame_d = frame_q + 16'd1;
            data_d  = 8'h00;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            data_d  = frame_byte(snap_q, idx_q + 1'b1);
            state_d = LOAD;
          end
        end else if (wd_expired) begin
          timeout = 1'b1;
          hdr_d   = 1'b0;
          data_d  = 8'h00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A timeout in the same cycle as errClr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (errClr)  err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk40M or negedge nRst)
    if (!nRst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      frame_q <= 16'h0000;
      err_q   <= 1'b0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      hdr_q   <= hdr_d;
    end

  // rd is combinational so fifoOut lands in POP; gate it off while in reset.
  assign rd           = (start_ok && nRst) ? '1 : '0;
  assign ldXmtDataReg = (state_q == LOAD);
  assign byteReady    = (state_q == READY);
  assign tByte        = (state_q == START);
  assign busy         = (state_q != IDLE);
  assign dataBus      = data_q;
  assign frameCnt     = frame_q;
  assign txErr        = err_q;
endmodule

// File: tb/tb_lvds_uart_scheduler.sv
// Directed bench for lvds_uart_scheduler; follows LVDS_SCHED_HDR_EN when defined.
`timescale 1ns/1ps
module tb_lvds_uart_scheduler;
  localparam int TO = 16;
`ifdef LVDS_SCHED_HDR_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif

  logic        clk40M = 1'b0;
  logic        nRst, en, txDone, errClr;
  logic [3:0]  empty;
  logic [63:0] fifoOut;
  logic [3:0]  rd;
  logic [7:0]  dataBus;
  logic        ldXmtDataReg, byteReady, tByte, busy, txErr;
  logic [15:0] frameCnt;

  lvds_uart_scheduler #(.TIMEOUT(TO), .HDR_BYTE(8'hA5)) dut (
    .clk40M(clk40M), .nRst(nRst), .en(en), .empty(empty), .fifoOut(fifoOut),
    .rd(rd), .dataBus(dataBus), .ldXmtDataReg(ldXmtDataReg), .byteReady(byteReady),
    .tByte(tByte), .txDone(txDone), .busy(busy), .frameCnt(frameCnt),
    .txErr(txErr), .errClr(errClr)
  );

  always #5 clk40M = ~clk40M;

  int checks = 0;
  int errors = 0;

  // Monitors update with NBAs so the main sequence sees settled counts at negedge.
  logic [7:0] txb [64];
  int  ntb = 0, nrd = 0, nbusy = 0;
  logic [3:0] rd_last = 4'h0;
  logic auto_tx = 1'b0;

  always @(negedge clk40M) begin
    if (tByte) begin
      if (ntb < 64) txb[ntb] <= dataBus;
      ntb <= ntb + 1;
    end
    if (rd != 4'h0) begin
      nrd     <= nrd + 1;
      rd_last <= rd;
    end
    if (busy) nbusy <= nbusy + 1;
  end

  // Transmitter model: txDone 5 cycles after each tByte.
  always begin
    @(negedge clk40M);
    if (auto_tx && tByte) begin
      repeat (5) @(posedge clk40M);
      #1 txDone = 1'b1;
      @(posedge clk40M);
      #1 txDone = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(posedge clk40M); #1 en = 1'b1;
    @(posedge clk40M); #1 en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk40M);
    while (busy && n < 600) begin @(negedge clk40M); n++; end
    chk(tag, 32'(n < 600), 32'd1);
    @(negedge clk40M);
  endtask

  // Stops on the negedge where tByte shows for transmitted byte k after base.
  task automatic wait_tb(input int k, input int base, input string tag);
    int n = 0;
    @(negedge clk40M);
    while (!(tByte && (ntb - base) == k) && n < 300) begin @(negedge clk40M); n++; end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  logic [7:0] e1 [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [7:0] e2 [8] = '{8'h01, 8'h00, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'hFF};
  localparam logic [63:0] P1 = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
  localparam logic [63:0] P2 = {16'hFF00, 16'h00FF, 16'hA55A, 16'h0001};

  initial begin
    int s, r, b, n;
    logic [7:0] ex;
    nRst = 1'b0; en = 1'b0; empty = 4'hF; fifoOut = '0; txDone = 1'b0; errClr = 1'b0;
    auto_tx = 1'b1;
    repeat (3) @(negedge clk40M);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_rd",     32'(rd), 0);
    chk("rst_data",   32'(dataBus), 0);
    chk("rst_strobe", 32'({ldXmtDataReg, byteReady, tByte}), 0);
    chk("rst_frame",  32'(frameCnt), 0);
    chk("rst_err",    32'(txErr), 0);
    @(posedge clk40M); #1 nRst = 1'b1;

    // Basic frame
    fifoOut = P1; empty = 4'h0;
    start_frame();
    wait_idle("f1_done");
    chk("f1_ntb", 32'(ntb), 32'(8 + HOFF));
    for (int i = 0; i < 8 + HOFF; i++) begin
      if (i < HOFF) ex = 8'hA5; else ex = e1[i - HOFF];
      chk($sformatf("f1_byte%0d", i), 32'(txb[i]), 32'(ex));
    end
    chk("f1_frame", 32'(frameCnt), 1);
    chk("f1_nrd",   32'(nrd), 1);
    chk("f1_rdval", 32'(rd_last), 32'hF);

    // One channel empty: no frame may start
    r = nrd; b = nbusy;
    empty = 4'b0100; en = 1'b1;
    repeat (100) @(negedge clk40M);
    chk("emp_rd",   32'(nrd - r), 0);
    chk("emp_busy", 32'(nbusy - b), 0);
    en = 1'b0; empty = 4'h0;

    // txDone in the same cycle the watchdog expires: txDone wins
    auto_tx = 1'b0;
    @(negedge clk40M); s = ntb;
    start_frame();
    wait_tb(0, s, "pri_tb");
    repeat (TO) @(posedge clk40M);
    #1 txDone = 1'b1;
    @(posedge clk40M); #1 txDone = 1'b0; auto_tx = 1'b1;
    @(negedge clk40M);
    chk("pri_load", 32'(ldXmtDataReg), 1);
    chk("pri_err",  32'(txErr), 0);
    wait_idle("pri_done");
    chk("pri_frame", 32'(frameCnt), 2);
    chk("pri_err2",  32'(txErr), 0);

    // Timeout with errClr held: set beats clear
    auto_tx = 1'b0; errClr = 1'b1;
    @(negedge clk40M); s = ntb;
    start_frame();
    wait_tb(0, s, "to_tb");
    n = 0;
    do begin @(negedge clk40M); n++; end while (!txErr && n < 40);
    chk("to_cycles", 32'(n), 32'(TO + 1));
    chk("to_err",    32'(txErr), 1);
    errClr = 1'b0;
    chk("to_busy",   32'(busy), 0);
    chk("to_frame",  32'(frameCnt), 2);
    repeat (3) @(negedge clk40M);
    chk("to_sticky", 32'(txErr), 1);
    @(posedge clk40M); #1 errClr = 1'b1;
    @(posedge clk40M); #1 errClr = 1'b0;
    @(negedge clk40M);
    chk("to_clr", 32'(txErr), 0);

    // en dropped during byte 3: frame completes, nothing follows
    auto_tx = 1'b1; fifoOut = P2;
    @(negedge clk40M); s = ntb; r = nrd;
    @(posedge clk40M); #1 en = 1'b1;
    wait_tb(HOFF + 3, s, "en_tb3");
    en = 1'b0;
    wait_idle("en_done");
    repeat (50) @(negedge clk40M);
    chk("en_ntb", 32'(ntb - s), 32'(8 + HOFF));
    for (int i = HOFF; i < 8 + HOFF; i++)
      chk($sformatf("en_byte%0d", i - HOFF), 32'(txb[s + i]), 32'(e2[i - HOFF]));
    chk("en_frame", 32'(frameCnt), 3);
    chk("en_nrd",   32'(nrd - r), 1);
    chk("en_busy",  32'(busy), 0);

    // Reset during WAIT of byte 5
    fifoOut = P1;
    @(negedge clk40M); s = ntb;
    start_frame();
    wait_tb(HOFF + 5, s, "rst_tb5");
    @(posedge clk40M); #1 nRst = 1'b0; en = 1'b1;
    @(negedge clk40M);
    chk("mrst_busy",   32'(busy), 0);
    chk("mrst_rd",     32'(rd), 0);
    chk("mrst_data",   32'(dataBus), 0);
    chk("mrst_strobe", 32'({ldXmtDataReg, byteReady, tByte}), 0);
    chk("mrst_frame",  32'(frameCnt), 0);
    chk("mrst_err",    32'(txErr), 0);
    en = 1'b0;
    @(posedge clk40M); #1 nRst = 1'b1;
    repeat (20) @(negedge clk40M);
    chk("post_busy",  32'(busy), 0);
    chk("post_frame", 32'(frameCnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
